// File: rtl/uop_buf_if.sv
// uop_buf_if: producer-side handshake and uop_fetch control bundle for uop_buf_ctrl
interface uop_buf_if #(parameter int UOP_BUF_SIZE = 16);
  localparam int AW = $clog2(UOP_BUF_SIZE);
  logic clear;
  logic wr_valid;
  logic wr_ready;
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic fetch_stalled;
  logic fetch_enable;
  logic fetch_valid;
  logic [AW-1:0] rd_addr;
  logic [AW:0] count;
  logic full;
  logic empty;
  modport master (
    output clear, wr_valid, fetch_stalled,
    input wr_ready, wr_en, wr_addr, fetch_enable, fetch_valid, rd_addr, count, full, empty
  );
  modport slave (
    input clear, wr_valid, fetch_stalled,
    output wr_ready, wr_en, wr_addr, fetch_enable, fetch_valid, rd_addr, count, full, empty
  );
endinterface

// File: rtl/uop_buf_ctrl.sv
// uop_buf_ctrl: micro-op buffer pointer/occupancy controller; UOP_BUF_STATS_EN adds hwm/stall_cycles stats
module uop_buf_ctrl #(
  parameter int UOP_BUF_SIZE = 16
) (
  input logic clk,
  input logic reset,
  uop_buf_if.slave bus
`ifdef UOP_BUF_STATS_EN
  ,
  output logic [$clog2(UOP_BUF_SIZE):0] hwm,
  output logic [15:0] stall_cycles
`endif
);
  localparam int AW = $clog2(UOP_BUF_SIZE);
  localparam logic [AW:0] DEPTH = (AW+1)'(UOP_BUF_SIZE);
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] count_q, count_d;
  logic flush, full, empty, wr_ready, fetch_enable, push, pop;
  assign flush = reset || bus.clear;
  assign full = count_q == DEPTH;
  assign empty = count_q == '0;
  assign wr_ready = !full && !flush;
  assign fetch_enable = !empty && !bus.fetch_stalled && !flush;
  assign push = bus.wr_valid && wr_ready;
  assign pop = fetch_enable;
  always_comb begin
    wptr_d = flush ? '0 : wptr_q + AW'(push);
    rptr_d = flush ? '0 : rptr_q + AW'(pop);
    count_d = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
    end
  end
  assign bus.wr_ready = wr_ready;
  assign bus.wr_en = push;
  assign bus.wr_addr = wptr_q;
  assign bus.fetch_enable = fetch_enable;
  assign bus.fetch_valid = fetch_enable;
  assign bus.rd_addr = rptr_q;
  assign bus.count = count_q;
  assign bus.full = full;
  assign bus.empty = empty;
`ifdef UOP_BUF_STATS_EN
  // statistics survive clear; only reset wipes them
  logic [AW:0] hwm_q;
  logic [15:0] stall_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      hwm_q <= '0;
      stall_q <= '0;
    end else begin
      if (count_d > hwm_q) hwm_q <= count_d;
      if (!empty && bus.fetch_stalled && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end
  assign hwm = hwm_q;
  assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_uop_buf_ctrl.sv
// tb_uop_buf_ctrl: randomized and directed scoreboard bench for uop_buf_ctrl
module tb_uop_buf_ctrl;
  localparam int N = 16;
  localparam int AW = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  uop_buf_if #(.UOP_BUF_SIZE(N)) bus ();
`ifdef UOP_BUF_STATS_EN
  logic [AW:0] hwm;
  logic [15:0] stall_cycles;
`endif
  uop_buf_ctrl #(.UOP_BUF_SIZE(N)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef UOP_BUF_STATS_EN
    ,
    .hwm(hwm),
    .stall_cycles(stall_cycles)
`endif
  );
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int sb[$];
  int cnt = 0;
  int wa = 0;
  int hwm_m = 0;
  int stall_m = 0;
  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction
  // reference model: occupancy as an integer, write address as push count mod N
  bit rc, m_rdy, m_fe, m_push;
  int nxt;
  always @(negedge clk) if (chk_en) begin
    rc = reset || bus.clear;
    m_rdy = cnt < N && !rc;
    m_fe = cnt > 0 && !bus.fetch_stalled && !rc;
    m_push = bus.wr_valid && m_rdy;
    chk("wr_ready", int'(bus.wr_ready), int'(m_rdy));
    chk("wr_en", int'(bus.wr_en), int'(m_push));
    chk("fetch_enable", int'(bus.fetch_enable), int'(m_fe));
    chk("fetch_valid", int'(bus.fetch_valid), int'(m_fe));
    chk("wr_addr", int'(bus.wr_addr), wa);
    chk("count", int'(bus.count), cnt);
    chk("full", int'(bus.full), int'(cnt == N));
    chk("empty", int'(bus.empty), int'(cnt == 0));
    if (m_push) sb.push_back(wa);
    nxt = rc ? 0 : cnt + int'(m_push) - int'(m_fe);
`ifdef UOP_BUF_STATS_EN
    chk("hwm", int'(hwm), hwm_m);
    chk("stall_cycles", int'(stall_cycles), stall_m);
    if (reset) begin
      hwm_m = 0;
      stall_m = 0;
    end else begin
      if (nxt > hwm_m) hwm_m = nxt;
      if (cnt > 0 && bus.fetch_stalled && stall_m < 65535) stall_m++;
    end
`endif
    if (rc) begin
      wa = 0;
      sb.delete();
    end else wa = (wa + int'(m_push)) % N;
    cnt = nxt;
  end
  always @(negedge clk) if (chk_en && bus.fetch_valid === 1'b1) begin
    if (sb.size() == 0) chk("pop_without_push", 1, 0);
    else chk("rd_order", int'(bus.rd_addr), sb.pop_front());
  end
  task automatic step(input bit v, input bit st, input bit cl);
    bus.wr_valid = v;
    bus.fetch_stalled = st;
    bus.clear = cl;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.wr_valid = 1'b0;
    bus.fetch_stalled = 1'b0;
    bus.clear = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    step(0, 0, 0);
    reset = 1'b0;
    repeat (5) step(0, 0, 0);
    chk("rd_addr_idle", int'(bus.rd_addr), 0);
    step(1, 0, 0);
    chk("rd_addr_after_push", int'(bus.rd_addr), 0);
    step(0, 0, 0);
    chk("rd_addr_after_pop", int'(bus.rd_addr), 1);
    repeat (2) step(0, 0, 0);
    repeat (17) step(1, 1, 0);
    chk("full_after_fill", int'(bus.full), 1);
    repeat (20) step(0, 0, 0);
    repeat (4) step(1, 1, 0);
    repeat (40) step(1, 0, 0);
    chk("count_steady", int'(bus.count), 4);
    repeat (10) step(0, 0, 0);
    reset = 1'b1;
    step(0, 0, 0);
    reset = 1'b0;
    repeat (7) step(1, 1, 0);
    chk("count_before_clear", int'(bus.count), 7);
    step(1, 1, 1);
    chk("count_after_clear", int'(bus.count), 0);
    chk("rd_addr_after_clear", int'(bus.rd_addr), 0);
    chk("wr_addr_after_clear", int'(bus.wr_addr), 0);
`ifdef UOP_BUF_STATS_EN
    chk("hwm_after_clear", int'(hwm), 7);
`endif
    repeat (3000) step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
`ifdef UOP_BUF_STATS_EN
    reset = 1'b1;
    step(0, 0, 0);
    reset = 1'b0;
    repeat (5) step(1, 1, 0);
    repeat (70000) step(0, 1, 0);
    chk("hwm_final", int'(hwm), 5);
    chk("stall_saturated", int'(stall_cycles), 65535);
`endif
    repeat (2) step(0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
